// File: rtl/relu_collector_if.sv
// relu_collector_if: activation input stream and replay output stream of
// relu_collector.
// Handshake:
//   - The input side has no ready. Every cycle with in_valid=1 is one beat.
//   - The output side transfers on any rising edge where out_valid and
//     out_ready are both 1.
//   - Once out_valid is high, out_data and out_last hold stable until that
//     transfer happens.
interface relu_collector_if #(
   parameter int DATA_W = 16
);
   logic [DATA_W-1:0] in_data;
   logic              in_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;
   logic              out_last;

   // Environment side: produces activations, consumes the replay.
   modport master (
      output in_data,
      output in_valid,
      output out_ready,
      input  out_data,
      input  out_valid,
      input  out_last
   );

   // Collector side.
   modport slave (
      input  in_data,
      input  in_valid,
      input  out_ready,
      output out_data,
      output out_valid,
      output out_last
   );
endinterface

// File: rtl/relu_collector.sv
// relu_collector: captures one layer of DEPTH ReLU activations, reports
// layer_done when the buffer is full, then replays the stored vector to the
// next layer over a valid/ready stream.
// Optional feature macro: RELU_COLLECT_MAX_EN. It adds max_data and max_idx,
// which track the running signed maximum of the layer (earliest index on a
// tie).
// state_dbg exposes the FSM state: 0 = FILL, 1 = FULL, 2 = DRAIN.
module relu_collector #(
   parameter  int DATA_W = 16,
   parameter  int DEPTH  = 64,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              reset,
   relu_collector_if.slave   bus,
   input  logic              rd_start,
   output logic              layer_done,
   output logic              overflow,
   output logic [ADDR_W:0]   count,
`ifdef RELU_COLLECT_MAX_EN
   output logic [DATA_W-1:0] max_data,
   output logic [ADDR_W-1:0] max_idx,
`endif
   output logic [1:0]        state_dbg
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {
      S_FILL  = 2'd0,
      S_FULL  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [ADDR_W-1:0] wr_ptr;
   logic [ADDR_W-1:0] rd_ptr;
   logic [ADDR_W-1:0] rd_addr;

   // Per-cycle actions decoded from the state and the inputs.
   logic wr_en;      // accept the incoming beat into mem[wr_ptr]
   logic drop;       // incoming beat arrives while the buffer is full
   logic launch;     // start a replay with element 0
   logic xfer;       // downstream takes the presented element
   logic xfer_last;  // that element was the final one of the layer

   assign state_dbg = state;

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FILL;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state decode and per-cycle action strobes.
   always_comb begin
      state_nxt = state;
      wr_en     = 1'b0;
      drop      = 1'b0;
      launch    = 1'b0;
      xfer      = 1'b0;
      xfer_last = 1'b0;
      case (state)
         S_FILL: begin
            // rd_start has no effect until the layer is complete.
            if (bus.in_valid) begin
               wr_en = 1'b1;
               if (wr_ptr == LAST_IDX) begin
                  state_nxt = S_FULL;
               end
            end
         end
         S_FULL: begin
            drop = bus.in_valid;
            if (rd_start) begin
               launch    = 1'b1;
               state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            drop = bus.in_valid;
            if (bus.out_valid && bus.out_ready) begin
               xfer = 1'b1;
               if (bus.out_last) begin
                  xfer_last = 1'b1;
                  state_nxt = S_FILL;
               end
            end
         end
         default: begin
            state_nxt = S_FILL;
         end
      endcase
   end

   // Launch fetches element 0. Each non-final transfer fetches the next
   // element so that it is presented on the following cycle.
   assign rd_addr = launch ? '0 : (rd_ptr + 1'b1);

   // Sample storage; contents survive reset on purpose.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= bus.in_data;
      end
   end

   // Write/read pointers and fill level.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : (wr_ptr + 1'b1);
            count  <= count + 1'b1;
         end
         if (launch) begin
            rd_ptr <= '0;
         end else if (xfer_last) begin
            // Layer handed off: the buffer is free for the next layer.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else if (xfer) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   // Registered replay outputs, completion pulse and sticky overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bus.out_valid <= 1'b0;
         bus.out_last  <= 1'b0;
         bus.out_data  <= '0;
         layer_done    <= 1'b0;
         overflow      <= 1'b0;
      end else begin
         layer_done <= wr_en && (wr_ptr == LAST_IDX);
         if (drop) begin
            overflow <= 1'b1;
         end
         if (launch || (xfer && !xfer_last)) begin
            bus.out_valid <= 1'b1;
            bus.out_data  <= mem[rd_addr];
            bus.out_last  <= (rd_addr == LAST_IDX);
         end else if (xfer_last) begin
            // out_data keeps its last value; only valid/last drop.
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
         end
      end
   end

`ifdef RELU_COLLECT_MAX_EN
   // Running signed maximum of the layer. The first write of a layer always
   // loads. A strict greater-than keeps the earliest index on a tie.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         max_data <= '0;
         max_idx  <= '0;
      end else if (wr_en &&
                   ((wr_ptr == '0) ||
                    ($signed(bus.in_data) > $signed(max_data)))) begin
         max_data <= bus.in_data;
         max_idx  <= wr_ptr;
      end
   end
`endif

endmodule
